dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for MEM-stage loads and stores
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_funct3         store flag and RV32I load/store width/sign code
//   req_addr, req_wdata        byte address and store data
//   resp_valid                 one-cycle pulse LATENCY edges after acceptance
//   resp_data, resp_err        extended load data (0 for stores/errors), error flag
//   busy                       request outstanding and not yet responding
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err,
    output logic            busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
    stateT state;
    logic [CW-1:0] cnt;
    logic weQ;
    logic [2:0] f3Q;
    logic [AW+1:0] addrQ;
    logic [31:0] wdataQ;
    logic [31:0] mem [DEPTH_WORDS];
    logic accept, enterResp, fromWait, cWe, cErr, misalign, legalLoad, legalStore, doWrite;
    logic [2:0] cF3;
    logic [AW+1:0] cAddr;
    logic [31:0] cWdata, memWord;
    logic [7:0] lb;
    logic [15:0] lh;
    logic [XLEN-1:0] ldData;
    logic unusedAddr;
    assign unusedAddr = ^req_addr[XLEN-1:AW+2];
    assign req_ready = state != WAIT;
    assign busy = state == WAIT;
    assign accept = req_valid && req_ready;
    // The commit edge is either the acceptance edge itself (LATENCY == 1) or the
    // WAIT edge where the counter runs out; pick the request fields accordingly.
    assign fromWait = state == WAIT;
    assign enterResp = rst_n && (fromWait ? cnt == CW'(1) : accept && LATENCY == 1);
    assign cWe = fromWait ? weQ : req_we;
    assign cF3 = fromWait ? f3Q : req_funct3;
    assign cAddr = fromWait ? addrQ : req_addr[AW+1:0];
    assign cWdata = fromWait ? wdataQ : req_wdata[31:0];
    assign memWord = mem[cAddr[AW+1:2]];
    always_comb begin
        legalLoad = cF3 != 3'b011 && cF3 != 3'b110 && cF3 != 3'b111;
        legalStore = !cF3[2] && cF3[1:0] != 2'b11;
        misalign = (cF3[1:0] == 2'b01 && cAddr[0]) || (cF3[1:0] == 2'b10 && cAddr[1:0] != 2'b00);
        cErr = (cWe ? !legalStore : !legalLoad) || misalign;
        doWrite = enterResp && cWe && !cErr;
        lb = memWord[{cAddr[1:0], 3'b000} +: 8];
        lh = cAddr[1] ? memWord[31:16] : memWord[15:0];
        // funct3[2] selects zero extension
        ldData = cF3[1:0] == 2'b00 ? {{(XLEN-8){lb[7] & ~cF3[2]}}, lb}
               : cF3[1:0] == 2'b01 ? {{(XLEN-16){lh[15] & ~cF3[2]}}, lh}
               : XLEN'(memWord);
    end
    // Array is not reset; writes are gated off while rst_n is low via enterResp.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            if (cF3[1])
                mem[cAddr[AW+1:2]] <= cWdata;
            else if (cF3[0])
                mem[cAddr[AW+1:2]][{cAddr[1], 4'b0000} +: 16] <= cWdata[15:0];
            else
                mem[cAddr[AW+1:2]][{cAddr[1:0], 3'b000} +: 8] <= cWdata[7:0];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            weQ        <= 1'b0;
            f3Q        <= '0;
            addrQ      <= '0;
            wdataQ     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= enterResp;
            if (enterResp) begin
                resp_data <= (cWe || cErr) ? '0 : ldData;
                resp_err  <= cErr;
            end
            if (accept) begin
                weQ    <= req_we;
                f3Q    <= req_funct3;
                addrQ  <= req_addr[AW+1:0];
                wdataQ <= req_wdata[31:0];
                cnt    <= CW'(LATENCY - 1);
                state  <= LATENCY == 1 ? RESP : WAIT;
            end else if (state == WAIT) begin
                cnt   <= cnt - CW'(1);
                state <= cnt == CW'(1) ? RESP : WAIT;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with directed vectors
module tb_dmem_responder;
    localparam int LAT = 2;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [2:0] req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_data;
    int checks = 0, errors = 0, cyc = 0;
    typedef struct { logic [31:0] d; logic e; int c; } expT;
    expT sb[$];
    bit inResp;

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_vs_busy", {31'd0, req_ready}, {31'd0, !busy});
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got data %h err %b expected none", resp_data, resp_err);
                end else begin
                    expT e;
                    e = sb.pop_front();
                    chk("resp_data", resp_data, e.d);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.e});
                    chk("latency_cycle", cyc, e.c);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee, input bit push, output bit wasResp);
        bit got = 0;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        wasResp = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req_ready) begin
                got = 1;
                wasResp = resp_valid;
                if (push) sb.push_back('{ed, ee, cyc + LAT});
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance addr %h", a);
        end
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee);
        bit r;
        issue(we, f3, a, wd, ed, ee, 1, r);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        bit r;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        op(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        op(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        op(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
        op(0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0);
        op(0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
        op(0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0);
        op(1, 3'b000, 32'h11, 32'h55, 32'h0, 0);
        op(1, 3'b001, 32'h12, 32'h1234, 32'h0, 0);
        op(0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 0);
        op(0, 3'b000, 32'h11, 32'h0, 32'h00000055, 0);
        op(0, 3'b001, 32'h12, 32'h0, 32'h00001234, 0);
        op(0, 3'b010, 32'h1010, 32'h0, 32'h123455EF, 0);
        op(0, 3'b010, 32'h12, 32'h0, 32'h0, 1);
        op(1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1);
        op(0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
        op(1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
        op(0, 3'b001, 32'h13, 32'h0, 32'h0, 1);
        op(1, 3'b010, 32'h13, 32'hFFFFFFFF, 32'h0, 1);
        op(0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 0);
        drain();
        issue(1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0, 0, 1, r);
        issue(0, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 0, 1, r);
        req_valid = 1'b0;
        chk("b2b_accept_in_resp", {31'd0, r}, 32'd1);
        drain();
        op(1, 3'b010, 32'h30, 32'h77, 32'h0, 0);
        drain();
        issue(1, 3'b010, 32'h30, 32'h1, 32'h0, 0, 0, r);
        req_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_busy_rst", {31'd0, busy}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_resp_data", resp_data, 32'd0);
        chk("abort_resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        op(0, 3'b010, 32'h30, 32'h0, 32'h77, 0);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
